// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a non-stallable ALU result stream and a FIFO-buffered
// load-return stream onto the single register-file write port, and tracks pending loads.
module wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              alu_valid,
    input  logic [3:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [3:0]        ld_issue_rd,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [3:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [3:0]        nD,
    output logic [DATA_W-1:0] D,
    output logic              RegWE,
    output logic [15:0]       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef struct packed {
        logic [3:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          alu_win;
    logic          push;
    logic          pop;
    entry_t        head;
    logic [15:0]   set_mask;
    logic [15:0]   clr_mask;

    // Ready comes from the registered count only, so a pop in this cycle never makes room.
    assign mem_ready = !Reset && (count < DEPTH_C);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        alu_win  = alu_valid && (alu_rd != 4'd0);
        push     = mem_valid && mem_ready && (mem_rd != 4'd0);
        pop      = !alu_win && (count != '0);
        head     = fifo_mem[rd_ptr];
        set_mask = '0;
        clr_mask = '0;
        if (ld_issue && (ld_issue_rd != 4'd0)) begin
            set_mask[ld_issue_rd] = 1'b1;
        end
        if (pop) begin
            clr_mask[head.rd] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            RegWE  <= 1'b0;
            nD     <= '0;
            D      <= '0;
            busy   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            RegWE <= alu_win || pop;
            if (alu_win) begin
                nD <= alu_rd;
                D  <= alu_data;
            end else if (pop) begin
                nD     <= head.rd;
                D      <= head.data;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear first, then set: a new issue to a register being retired keeps it busy.
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // NOTE: the entry storage is deliberately not reset; count and the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{rd: mem_rd, data: mem_data};
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (Reset) count <= DEPTH_C);
    a_no_r0_write : assert property (@(posedge clk) disable iff (Reset) RegWE |-> (nD != 4'd0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based behavioural model.
module tb_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              Reset;
    logic              alu_valid;
    logic [3:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [3:0]        ld_issue_rd;
    logic              mem_valid;
    logic              mem_ready;
    logic [3:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [3:0]        nD;
    logic [DATA_W-1:0] D;
    logic              RegWE;
    logic [15:0]       busy;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .Reset(Reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .nD(nD), .D(D), .RegWE(RegWE), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]        rd;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             q[$];
    logic              m_we;
    logic [3:0]        m_nd;
    logic [DATA_W-1:0] m_d;
    bit                m_busy[16];
    bit                m_acc;

    function automatic logic [15:0] model_busy();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_busy[i];
        return r;
    endfunction

    task automatic model_step();
        beat_t b;
        bit    room;
        m_acc = 1'b0;
        if (Reset) begin
            q.delete();
            m_we = 1'b0;
            m_nd = '0;
            m_d  = '0;
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        end else begin
            room = (q.size() < DEPTH);
            if (alu_valid && alu_rd != 4'd0) begin
                m_we = 1'b1; m_nd = alu_rd; m_d = alu_data;
            end else if (q.size() > 0) begin
                b = q.pop_front();
                m_we = 1'b1; m_nd = b.rd; m_d = b.data;
                m_busy[b.rd] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (ld_issue && ld_issue_rd != 4'd0) m_busy[ld_issue_rd] = 1'b1;
            if (mem_valid && room) begin
                m_acc = 1'b1;
                if (mem_rd != 4'd0) q.push_back('{rd: mem_rd, data: mem_data});
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process: every cycle once the first reset has been applied.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_RegWE",     32'(RegWE),     32'(m_we));
            check("m_nD",        32'(nD),        32'(m_nd));
            check("m_D",         32'(D),         32'(m_d));
            check("m_busy",      32'(busy),      32'(model_busy()));
            check("m_mem_ready", 32'(mem_ready), 32'(!Reset && (q.size() < DEPTH)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic drive_alu(input logic [3:0] rd, input logic [DATA_W-1:0] data);
        alu_valid = 1'b1; alu_rd = rd; alu_data = data;
    endtask

    task automatic drive_mem(input logic [3:0] rd, input logic [DATA_W-1:0] data);
        mem_valid = 1'b1; mem_rd = rd; mem_data = data;
    endtask

    task automatic drive_ld(input logic [3:0] rd);
        ld_issue = 1'b1; ld_issue_rd = rd;
    endtask

    logic [3:0]        got_rd[6];
    logic [DATA_W-1:0] got_d[6];
    int                n_got;
    int                bi;
    int                alu_pct;

    initial begin
        Reset = 1'b1;
        idle();

        // Reset held for two edges, then released.
        step(); step();
        Reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_RegWE",     32'(RegWE),     32'h0);
        check("rst_nD",        32'(nD),        32'h0);
        check("rst_D",         32'(D),         32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h1);

        // ALU only, then an ALU result to r0 which must not write.
        step(); drive_alu(4'd5, 16'h1234);
        step(); idle();
        @(negedge clk);
        check("alu_RegWE", 32'(RegWE), 32'h1);
        check("alu_nD",    32'(nD),    32'h5);
        check("alu_D",     32'(D),     32'h1234);
        drive_alu(4'd0, 16'hFFFF);
        step(); idle();
        @(negedge clk);
        check("alu_r0_RegWE", 32'(RegWE), 32'h0);
        check("alu_r0_nD",    32'(nD),    32'h5);
        check("alu_r0_D",     32'(D),     32'h1234);

        // Load round trip to r7.
        step(); drive_ld(4'd7);
        step(); idle();
        @(negedge clk);
        check("ld_busy_set", 32'(busy), 32'h0080);
        step(); drive_mem(4'd7, 16'hBEEF);
        step(); idle();
        @(negedge clk);
        check("ld_n1_RegWE", 32'(RegWE), 32'h0);
        check("ld_n1_busy",  32'(busy),  32'h0080);
        step();
        @(negedge clk);
        check("ld_n2_RegWE", 32'(RegWE), 32'h1);
        check("ld_n2_nD",    32'(nD),    32'h7);
        check("ld_n2_D",     32'(D),     32'hBEEF);
        check("ld_n2_busy",  32'(busy),  32'h0000);

        // Priority and order: ALU r1, r2, r6 then loads r3, r4, back to back.
        step(); drive_alu(4'd1, 16'h0111); drive_mem(4'd3, 16'h3333);
        step(); drive_alu(4'd2, 16'h0222); drive_mem(4'd4, 16'h4444);
        @(negedge clk);
        check("prio_w1", 32'({RegWE, nD}), 32'h11);
        step(); idle(); drive_alu(4'd6, 16'h0666);
        @(negedge clk);
        check("prio_w2", 32'({RegWE, nD}), 32'h12);
        step(); idle();
        @(negedge clk);
        check("prio_w3", 32'({RegWE, nD}), 32'h16);
        step();
        @(negedge clk);
        check("prio_w4", 32'({RegWE, nD, D}), 32'h133333);
        step();
        @(negedge clk);
        check("prio_w5", 32'({RegWE, nD, D}), 32'h144444);
        step();
        @(negedge clk);
        check("prio_idle", 32'(RegWE), 32'h0);

        // Back-pressure: ALU held while six beats are offered to a four-deep FIFO.
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (m_acc) bi++;
            idle();
            drive_alu(4'd1, 16'(c));
            if (bi < 6) drive_mem(4'(8 + bi), 16'hA000 + 16'(bi));
        end
        @(negedge clk);
        check("bp_accepted", 32'(bi), 32'd4);
        check("bp_ready_full", 32'(mem_ready), 32'h0);
        step();
        if (m_acc) bi++;
        idle();
        drive_mem(4'(8 + bi), 16'hA000 + 16'(bi));
        @(negedge clk);
        check("bp_ready_pop_cycle", 32'(mem_ready), 32'h0);
        n_got = 0;
        for (int c = 0; c < 30 && n_got < 6; c++) begin
            step();
            if (m_acc) bi++;
            idle();
            if (bi < 6) drive_mem(4'(8 + bi), 16'hA000 + 16'(bi));
            @(negedge clk);
            if (c == 0) check("bp_ready_after_pop", 32'(mem_ready), 32'h1);
            if (RegWE && nD != 4'd1) begin
                got_rd[n_got] = nD;
                got_d[n_got]  = D;
                n_got++;
            end
        end
        check("bp_write_count", 32'(n_got), 32'd6);
        for (int i = 0; i < n_got; i++) begin
            check("bp_order_rd", 32'(got_rd[i]), 32'(8 + i));
            check("bp_order_d",  32'(got_d[i]),  32'(16'hA000 + 16'(i)));
        end
        step(); idle();
        step();

        // Simultaneous set and clear on r9.
        step(); drive_ld(4'd9);
        step(); idle(); drive_mem(4'd9, 16'h9999);
        step(); idle(); drive_ld(4'd9);
        step(); idle();
        @(negedge clk);
        check("sc_RegWE", 32'({RegWE, nD, D}), 32'h199999);
        check("sc_busy",  32'(busy), 32'h0200);
        step(); drive_mem(4'd9, 16'h0909);
        step(); idle();
        step(); step();
        @(negedge clk);
        check("sc_cleanup_busy", 32'(busy), 32'h0000);

        // Reset with two entries queued behind a held ALU stream.
        step(); drive_ld(4'd10);
        step(); idle(); drive_ld(4'd11);
        step(); idle(); drive_alu(4'd2, 16'h0002); drive_mem(4'd10, 16'h1010);
        step(); idle(); drive_alu(4'd2, 16'h0003); drive_mem(4'd11, 16'h1111);
        step(); idle(); drive_alu(4'd2, 16'h0004);
        @(negedge clk);
        check("rq_busy", 32'(busy), 32'h0C00);
        step(); Reset = 1'b1; drive_alu(4'd2, 16'h0005); drive_mem(4'd12, 16'h1212);
        step(); Reset = 1'b0; idle();
        @(negedge clk);
        check("rq_RegWE",     32'(RegWE),     32'h0);
        check("rq_nD",        32'(nD),        32'h0);
        check("rq_busy_clr",  32'(busy),      32'h0);
        check("rq_mem_ready", 32'(mem_ready), 32'h1);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            check("rq_no_write", 32'(RegWE), 32'h0);
        end

        // Randomized traffic with alternating light and heavy ALU phases.
        for (int c = 0; c < 3000; c++) begin
            step();
            idle();
            alu_pct = ((c / 200) % 2 == 1) ? 92 : 35;
            Reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 99) < alu_pct) drive_alu(4'($urandom), 16'($urandom));
            if ($urandom_range(0, 99) < 55) drive_mem(4'($urandom), 16'($urandom));
            ld_issue_rd = 4'($urandom);
            ld_issue = ($urandom_range(0, 99) < 30) && !m_busy[ld_issue_rd];
        end
        step(); Reset = 1'b0; idle();
        step();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
